// File: rtl/alu_exec_stage_pkg.sv
// CPU_package: shared CPU types for the datapath.
//   DATA_WIDTH          - datapath width
//   enum_alu_opcode_t   - ALU operation selector
//   struct_alu_flag_t   - ALU status flags {carry, zero, negative, overflow}
//   enum_exec_state_t   - execute stage FSM states
//   is_multicycle()     - opcodes that need the multicycle window in EXEC
package CPU_package;

  localparam int DATA_WIDTH = 16;

  typedef enum logic [3:0] {
    ALU_OP_ADD = 4'd0,
    ALU_OP_SUB = 4'd1,
    ALU_OP_AND = 4'd2,
    ALU_OP_OR  = 4'd3,
    ALU_OP_XOR = 4'd4,
    ALU_OP_SHL = 4'd5,
    ALU_OP_SHR = 4'd6,
    ALU_OP_MUL = 4'd7,
    ALU_OP_DIV = 4'd8,
    ALU_OP_CPR = 4'd9
  } enum_alu_opcode_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
  } struct_alu_flag_t;

  typedef enum logic [1:0] {
    EXEC_IDLE = 2'd0,
    EXEC_RUN  = 2'd1,
    EXEC_DONE = 2'd2
  } enum_exec_state_t;

  function automatic logic is_multicycle(input enum_alu_opcode_t opcode);
    return (opcode == ALU_OP_MUL) || (opcode == ALU_OP_DIV);
  endfunction

endpackage

// File: rtl/alu_exec_stage_alu.sv
// ALU: purely combinational arithmetic/logic unit.
//   alu_a, alu_b   in   DATA_WIDTH operands
//   alu_opcode     in   operation select
//   alu_mode       in   SHL: rotate carry in; SHR: arithmetic; CPR: signed compare
//   input_carry    in   carry-in for ADD/SUB/SHL-rotate
//   alu_out        out  DATA_WIDTH result
//   alu_out_flag   out  flags derived from this operation
module ALU
  import CPU_package::*;
(
  input  logic [DATA_WIDTH-1:0] alu_a,
  input  logic [DATA_WIDTH-1:0] alu_b,
  input  enum_alu_opcode_t      alu_opcode,
  input  logic                  alu_mode,
  input  logic                  input_carry,
  output logic [DATA_WIDTH-1:0] alu_out,
  output struct_alu_flag_t      alu_out_flag
);

  localparam int MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH:0]     sum_ext;
  logic [DATA_WIDTH:0]     diff_ext;
  logic [DATA_WIDTH:0]     cmp_ext;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [DATA_WIDTH-1:0]   result;
  logic                    carry;
  logic                    overflow;

  // Extended-width sum/difference so the top bit is the carry/borrow out.
  assign sum_ext  = {1'b0, alu_a} + {1'b0, alu_b} + {{DATA_WIDTH{1'b0}}, input_carry};
  assign diff_ext = {1'b0, alu_a} - {1'b0, alu_b} - {{DATA_WIDTH{1'b0}}, input_carry};
  assign cmp_ext  = {1'b0, alu_a} - {1'b0, alu_b};
  assign prod     = {{DATA_WIDTH{1'b0}}, alu_a} * {{DATA_WIDTH{1'b0}}, alu_b};

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    unique case (alu_opcode)
      ALU_OP_ADD: begin
        result   = sum_ext[MSB:0];
        carry    = sum_ext[DATA_WIDTH];
        overflow = (alu_a[MSB] == alu_b[MSB]) && (result[MSB] != alu_a[MSB]);
      end
      ALU_OP_SUB: begin
        // carry holds the borrow out
        result   = diff_ext[MSB:0];
        carry    = diff_ext[DATA_WIDTH];
        overflow = (alu_a[MSB] != alu_b[MSB]) && (result[MSB] != alu_a[MSB]);
      end
      ALU_OP_AND: result = alu_a & alu_b;
      ALU_OP_OR:  result = alu_a | alu_b;
      ALU_OP_XOR: result = alu_a ^ alu_b;
      ALU_OP_SHL: begin
        result = {alu_a[MSB-1:0], alu_mode ? input_carry : 1'b0};
        carry  = alu_a[MSB];
      end
      ALU_OP_SHR: begin
        result = {alu_mode ? alu_a[MSB] : 1'b0, alu_a[MSB:1]};
        carry  = alu_a[0];
      end
      ALU_OP_MUL: begin
        // carry flags that the product did not fit in DATA_WIDTH
        result = prod[MSB:0];
        carry  = |prod[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      ALU_OP_DIV: begin
        if (alu_b == '0) begin
          result   = '1;
          overflow = 1'b1;
        end else begin
          result = alu_a / alu_b;
        end
      end
      ALU_OP_CPR: begin
        // carry = "a below b", unsigned or signed depending on mode
        result = cmp_ext[MSB:0];
        carry  = alu_mode ? ($signed(alu_a) < $signed(alu_b)) : cmp_ext[DATA_WIDTH];
      end
      default: result = '0;
    endcase
  end

  assign alu_out               = result;
  assign alu_out_flag.carry    = carry;
  assign alu_out_flag.zero     = (result == '0);
  assign alu_out_flag.negative = result[MSB];
  assign alu_out_flag.overflow = overflow;

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage around the ALU.
// Accepts one op per valid/ready handshake, runs it from latched operands,
// registers result and flags, and owns the architectural flag register.
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  upstream handshake (in_ready is combinational from out_ready)
//   in_a, in_b      operands
//   in_opcode       ALU opcode
//   in_mode         forwarded to alu_mode
//   in_use_carry    1: ALU carry-in comes from flag_reg.carry
//   in_set_flags    1: this op's flags are written into flag_reg
//   out_valid/ready downstream handshake
//   out_result      registered ALU result
//   out_flag        registered ALU flags of this op
//   flag_reg        architectural flags
module alu_exec_stage
  import CPU_package::*;
#(
  parameter int               MULDIV_CYCLES = 4,
  parameter struct_alu_flag_t FLAG_RESET    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  enum_alu_opcode_t      in_opcode,
  input  logic                  in_mode,
  input  logic                  in_use_carry,
  input  logic                  in_set_flags,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output struct_alu_flag_t      out_flag,
  output struct_alu_flag_t      flag_reg
);

  localparam int                CNT_W       = $clog2(MULDIV_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  MULDIV_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  enum_exec_state_t      state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] lat_a;
  logic [DATA_WIDTH-1:0] lat_b;
  enum_alu_opcode_t      lat_opcode;
  logic                  lat_mode;
  logic                  lat_use_carry;
  logic                  lat_set_flags;

  logic [DATA_WIDTH-1:0] alu_out;
  struct_alu_flag_t      alu_out_flag;
  logic                  input_carry;
  logic                  accept;

  // Ready in DONE depends on out_ready so a finished op can hand off to the
  // next one on the same edge; this is a deliberate combinational path.
  assign in_ready = (state == EXEC_IDLE) || ((state == EXEC_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Carry-in reads the live flag register, so an op accepted right after a
  // set_flags op sees the carry captured on the previous edge.
  assign input_carry = lat_use_carry ? flag_reg.carry : 1'b0;

  ALU u_alu (
    .alu_a        (lat_a),
    .alu_b        (lat_b),
    .alu_opcode   (lat_opcode),
    .alu_mode     (lat_mode),
    .input_carry  (input_carry),
    .alu_out      (alu_out),
    .alu_out_flag (alu_out_flag)
  );

  // Control FSM with registered outputs. Operand latches load only on an
  // accepted handshake so upstream wiggles in EXEC/DONE are invisible; reset
  // drops any in-flight op without touching flag_reg beyond FLAG_RESET.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= EXEC_IDLE;
      cnt           <= '0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_flag      <= '0;
      flag_reg      <= FLAG_RESET;
      lat_a         <= '0;
      lat_b         <= '0;
      lat_opcode    <= ALU_OP_ADD;
      lat_mode      <= 1'b0;
      lat_use_carry <= 1'b0;
      lat_set_flags <= 1'b0;
    end else begin
      unique case (state)
        EXEC_IDLE: begin
          if (in_valid) state <= EXEC_RUN;
        end
        EXEC_RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            out_result <= alu_out;
            out_flag   <= alu_out_flag;
            out_valid  <= 1'b1;
            if (lat_set_flags) flag_reg <= alu_out_flag;
            state      <= EXEC_DONE;
          end
        end
        EXEC_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= in_valid ? EXEC_RUN : EXEC_IDLE;
          end
        end
        default: state <= EXEC_IDLE;
      endcase

      if (accept) begin
        lat_a         <= in_a;
        lat_b         <= in_b;
        lat_opcode    <= in_opcode;
        lat_mode      <= in_mode;
        lat_use_carry <= in_use_carry;
        lat_set_flags <= in_set_flags;
        cnt           <= is_multicycle(in_opcode) ? MULDIV_LOAD : '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: self-checking bench for alu_exec_stage.
// Expected results are queued when an op is driven and popped when the
// stage raises out_valid.
module tb_alu_exec_stage;
  import CPU_package::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  enum_alu_opcode_t      in_opcode;
  logic                  in_mode;
  logic                  in_use_carry;
  logic                  in_set_flags;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_result;
  struct_alu_flag_t      out_flag;
  struct_alu_flag_t      flag_reg;

  typedef struct {
    logic [DATA_WIDTH-1:0] result;
    logic [3:0]            flag;
  } exp_t;

  exp_t scoreboard[$];
  int   checks = 0;
  int   passed = 0;

  alu_exec_stage #(.MULDIV_CYCLES(4), .FLAG_RESET('0)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_opcode    (in_opcode),
    .in_mode      (in_mode),
    .in_use_carry (in_use_carry),
    .in_set_flags (in_set_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flag     (out_flag),
    .flag_reg     (flag_reg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed === expected) passed++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveOp(input enum_alu_opcode_t op, input logic [DATA_WIDTH-1:0] a,
                         input logic [DATA_WIDTH-1:0] b, input logic mode,
                         input logic uc, input logic sf);
    in_valid     = 1'b1;
    in_opcode    = op;
    in_a         = a;
    in_b         = b;
    in_mode      = mode;
    in_use_carry = uc;
    in_set_flags = sf;
  endtask

  task automatic pushExpected(input logic [DATA_WIDTH-1:0] res, input logic [3:0] flg);
    exp_t e;
    e.result = res;
    e.flag   = flg;
    scoreboard.push_back(e);
  endtask

  task automatic popAndCompare(input string tag);
    exp_t e;
    if (scoreboard.size() == 0) begin
      checkOutput({tag, " scoreboard empty"}, 32'(scoreboard.size()), 32'd1);
    end else begin
      e = scoreboard.pop_front();
      checkOutput({tag, " result"}, 32'(out_result), 32'(e.result));
      checkOutput({tag, " out_flag"}, 32'(out_flag), 32'(e.flag));
    end
  endtask

  // Returns number of edges after the accept edge until out_valid is seen.
  task automatic waitValid(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 20);
  endtask

  task automatic applyStimulus(input string tag, input enum_alu_opcode_t op,
                               input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b,
                               input logic mode, input logic uc, input logic sf,
                               input logic [DATA_WIDTH-1:0] exp_res, input logic [3:0] exp_flg,
                               input int exp_lat);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
    driveOp(op, a, b, mode, uc, sf);
    pushExpected(exp_res, exp_flg);
    tick();
    in_valid = 1'b0;
    waitValid(lat);
    checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
    popAndCompare(tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_opcode = ALU_OP_ADD;
    in_mode = 1'b0;
    in_use_carry = 1'b0;
    in_set_flags = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_result", 32'(out_result), 32'd0);
    checkOutput("reset out_flag", 32'(out_flag), 32'd0);
    checkOutput("reset flag_reg", 32'(flag_reg), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);

    // Basic ADD, then carry chain through flag_reg.
    applyStimulus("add 3+5", ALU_OP_ADD, 16'd3, 16'd5, 1'b0, 1'b0, 1'b0, 16'd8, 4'b0000, 1);
    applyStimulus("add ffff+1", ALU_OP_ADD, 16'hFFFF, 16'd1, 1'b0, 1'b0, 1'b1, 16'd0, 4'b1100, 1);
    checkOutput("flag_reg after set_flags", 32'(flag_reg), 32'h0000_000C);
    applyStimulus("add carry-in", ALU_OP_ADD, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd1, 4'b0000, 1);
    checkOutput("flag_reg kept", 32'(flag_reg), 32'h0000_000C);

    // Multicycle ops.
    applyStimulus("mul 2*2", ALU_OP_MUL, 16'd2, 16'd2, 1'b0, 1'b0, 1'b0, 16'd4, 4'b0000, 4);
    applyStimulus("div 10/2", ALU_OP_DIV, 16'd10, 16'd2, 1'b0, 1'b0, 1'b0, 16'd5, 4'b0000, 4);

    // Flags reported without touching flag_reg.
    applyStimulus("sub 5-7", ALU_OP_SUB, 16'd5, 16'd7, 1'b0, 1'b0, 1'b0, 16'hFFFE, 4'b1010, 1);
    applyStimulus("cpr 20,10", ALU_OP_CPR, 16'd20, 16'd10, 1'b0, 1'b0, 1'b0, 16'd10, 4'b0000, 1);
    checkOutput("flag_reg after no-set ops", 32'(flag_reg), 32'h0000_000C);

    // Backpressure: hold DONE, wiggle upstream, then back-to-back handoff.
    driveOp(ALU_OP_ADD, 16'd1, 16'd2, 1'b0, 1'b0, 1'b0);
    pushExpected(16'd3, 4'b0000);
    tick();
    in_valid = 1'b0;
    waitValid(lat);
    checkOutput("bp first latency", 32'(lat), 32'd1);
    popAndCompare("bp first");
    driveOp(ALU_OP_ADD, 16'd4, 16'd4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_a = 16'h1111 * 16'(i + 1);
      tick();
      checkOutput("bp hold result", 32'(out_result), 32'd3);
      checkOutput("bp hold out_flag", 32'(out_flag), 32'd0);
      checkOutput("bp hold in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp hold out_valid", 32'(out_valid), 32'd1);
    end
    in_a = 16'd4;
    out_ready = 1'b1;
    #1;
    checkOutput("bp release in_ready", 32'(in_ready), 32'd1);
    pushExpected(16'd8, 4'b0000);
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    checkOutput("bp handoff out_valid", 32'(out_valid), 32'd0);
    tick();
    checkOutput("bp second out_valid", 32'(out_valid), 32'd1);
    popAndCompare("bp second");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of a MUL that would have set flags.
    driveOp(ALU_OP_MUL, 16'd3, 16'd3, 1'b0, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid-reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid-reset flag_reg", 32'(flag_reg), 32'd0);
    checkOutput("mid-reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("mid-reset out_result", 32'(out_result), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    checkOutput("no result after reset", 32'(seen), 32'd0);
    checkOutput("flag_reg after discard", 32'(flag_reg), 32'd0);
    checkOutput("scoreboard drained", 32'(scoreboard.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
